// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU definitions: 3-bit opcode map and multiply sequencer state encoding.
// The ALU control decoder and the multiply sequencer both take opcodes from here.
package alu_mul_seq_pkg;

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_XOR = 3'b011;
    localparam logic [2:0] ALU_OP_NOR = 3'b100;
    localparam logic [2:0] ALU_OP_SLL = 3'b101;
    localparam logic [2:0] ALU_OP_SUB = 3'b110;
    localparam logic [2:0] ALU_OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned 16x16->32 shift-add multiplier that borrows the shared 16-bit ALU
// for its adds: one iteration per cycle, 17 cycles from accept to done.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter logic [2:0] OP_ADD = ALU_OP_ADD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] multiplicand,
    input  logic [15:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [2:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    input  logic        alu_co,
    output state_t      dbg_state
);

    // Handshake: start is accepted only when busy is low (IDLE); a request
    // while busy is dropped, never queued. done pulses for exactly one cycle
    // and product then holds until the next accepted start.

    state_t      state, state_nxt;
    logic [15:0] mcand;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [3:0]  cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        alu_op    = OP_ADD;
        alu_a     = 16'h0000;
        alu_b     = 16'h0000;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy  = 1'b1;
                alu_a = hi;
                // Adding zero when the multiplier bit is clear keeps every
                // iteration on the same path; carry-out is then zero.
                alu_b = lo[0] ? mcand : 16'h0000;
                if (cnt == 4'd15) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= 16'h0000;
            hi      <= 16'h0000;
            lo      <= 16'h0000;
            cnt     <= 4'd0;
            product <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= multiplicand;
                        hi    <= 16'h0000;
                        lo    <= multiplier;
                        cnt   <= 4'd0;
                    end
                end
                RUN: begin
                    // Carry re-enters at the top so the 17-bit partial sum is kept.
                    {hi, lo} <= {alu_co, alu_result, lo[15:1]};
                    cnt      <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        product <= {alu_co, alu_result, lo[15:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
